// File: rtl/line_fill_unit_if.sv
// ============================================================================
// Module      : line_fill_unit_if
// Description : Bundle of the fill-request, memory read and data-line array
//               write signals used by line_fill_unit. The master modport is
//               the fill engine's view; the slave modport is the view of the
//               surrounding cache controller, memory and array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_fill_unit_if #(
    parameter int XLEN           = 32,
    parameter int SET_SIZE       = 2,
    parameter int WORDS_PER_LINE = 8,
    parameter int ASSOC          = 1
);
    localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE);
    localparam int TAG_SIZE         = XLEN - SET_SIZE - WORD_SELECT_SIZE - 2;
    localparam int WAY_SIZE         = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    // Fill request from the cache controller
    logic                        fill_req;
    logic [TAG_SIZE-1:0]         fill_tag;
    logic [SET_SIZE-1:0]         fill_set;
    logic [WAY_SIZE-1:0]         fill_way;
    logic [WORD_SELECT_SIZE-1:0] fill_word;
    logic                        fill_busy;
    logic                        fill_done;

    // Read channel to the next memory level
    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic [XLEN-1:0]             mem_req_addr;
    logic                        mem_rsp_valid;
    logic [XLEN-1:0]             mem_rsp_data;

    // Data-line array write port
    logic                        dl_perform_write;
    logic [SET_SIZE-1:0]         dl_set;
    logic [WAY_SIZE-1:0]         dl_selected_way;
    logic [WORD_SELECT_SIZE-1:0] dl_word_select;
    logic [XLEN-1:0]             dl_word_to_store;

    modport master (
        input  fill_req, fill_tag, fill_set, fill_way, fill_word,
        output fill_busy, fill_done,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output dl_perform_write, dl_set, dl_selected_way, dl_word_select,
        output dl_word_to_store
    );

    modport slave (
        output fill_req, fill_tag, fill_set, fill_way, fill_word,
        input  fill_busy, fill_done,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  dl_perform_write, dl_set, dl_selected_way, dl_word_select,
        input  dl_word_to_store
    );
endinterface

`default_nettype wire

// File: rtl/line_fill_unit.sv
// ============================================================================
// Module      : line_fill_unit
// Description : Cache-miss line fill engine. Fetches every word of a missed
//               line from the next memory level with a single outstanding
//               read, writes each returned word into the data-line array as
//               a full-word store, and pulses fill_done on completion.
//               Optional feature macro: CRITICAL_WORD_FIRST_EN (start the
//               fill at the missing word and wrap around the line).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_fill_unit #(
    parameter int XLEN           = 32,
    parameter int NUM_SETS       = 4,
    parameter int SET_SIZE       = 2,
    parameter int WORDS_PER_LINE = 8,
    parameter int ASSOC          = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    line_fill_unit_if.master   bus
);
    localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE);
    localparam int TAG_SIZE         = XLEN - SET_SIZE - WORD_SELECT_SIZE - 2;
    localparam int WAY_SIZE         = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int COUNT_SIZE       = WORD_SELECT_SIZE + 1;

    // Count value held while the final response of a line is being written
    localparam logic [COUNT_SIZE-1:0] c_LAST_COUNT = COUNT_SIZE'(WORDS_PER_LINE - 1);
    localparam logic [WORD_SELECT_SIZE-1:0] c_WORD_ONE = WORD_SELECT_SIZE'(1);

    // Elaboration-time sanity checks on the parameter set
    generate
        if (SET_SIZE != $clog2(NUM_SETS)) begin : g_bad_set_size
            $error("line_fill_unit: SET_SIZE must equal clog2(NUM_SETS)");
        end
        if ((WORDS_PER_LINE < 2) || ((1 << WORD_SELECT_SIZE) != WORDS_PER_LINE)) begin : g_bad_line_size
            $error("line_fill_unit: WORDS_PER_LINE must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                       r_state;

    // Latched fill request
    logic [TAG_SIZE-1:0]          r_tag;
    logic [SET_SIZE-1:0]          r_set;
    logic [WAY_SIZE-1:0]          r_way;
    logic [WORD_SELECT_SIZE-1:0]  r_word_idx;
    logic [COUNT_SIZE-1:0]        r_count;

    // Captured response, written to the array on the following edge
    logic                         r_rsp_captured;
    logic [XLEN-1:0]              r_rsp_data;
    logic [WORD_SELECT_SIZE-1:0]  r_rsp_idx;

    // Registered outputs
    logic                         r_mem_req_valid;
    logic                         r_fill_done;
    logic                         r_perform_write;
    logic [SET_SIZE-1:0]          r_dl_set;
    logic [WAY_SIZE-1:0]          r_dl_way;
    logic [WORD_SELECT_SIZE-1:0]  r_dl_word;
    logic [XLEN-1:0]              r_dl_data;

    logic [WORD_SELECT_SIZE-1:0]  w_start_word;

`ifdef CRITICAL_WORD_FIRST_EN
    // The missing word is fetched first; the rest of the line follows it
    assign w_start_word = bus.fill_word;
`else
    // Fills always run in ascending order from word 0
    assign w_start_word = '0;
    logic w_unused_fill_word;
    assign w_unused_fill_word = ^bus.fill_word;
`endif

    // Fill sequencer: request, wait/capture, write-back, completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_tag           <= '0;
            r_set           <= '0;
            r_way           <= '0;
            r_word_idx      <= '0;
            r_count         <= '0;
            r_rsp_captured  <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_idx       <= '0;
            r_mem_req_valid <= 1'b0;
            r_fill_done     <= 1'b0;
            r_perform_write <= 1'b0;
            r_dl_set        <= '0;
            r_dl_way        <= '0;
            r_dl_word       <= '0;
            r_dl_data       <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_perform_write <= 1'b0;
            r_fill_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.fill_req) begin
                        r_tag           <= bus.fill_tag;
                        r_set           <= bus.fill_set;
                        r_way           <= bus.fill_way;
                        r_word_idx      <= w_start_word;
                        r_count         <= '0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Address is built from registers, so it is stable
                    // for as long as the memory stalls
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_rsp_captured  <= 1'b0;
                        r_state         <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (!r_rsp_captured) begin
                        if (bus.mem_rsp_valid) begin
                            r_rsp_data     <= bus.mem_rsp_data;
                            r_rsp_idx      <= r_word_idx;
                            r_rsp_captured <= 1'b1;
                        end
                    end else begin
                        // Write the captured word while the next request
                        // (or the completion pulse) goes out
                        r_rsp_captured  <= 1'b0;
                        r_perform_write <= 1'b1;
                        r_dl_set        <= r_set;
                        r_dl_way        <= r_way;
                        r_dl_word       <= r_rsp_idx;
                        r_dl_data       <= r_rsp_data;
                        r_count         <= r_count + COUNT_SIZE'(1);
                        r_word_idx      <= r_word_idx + c_WORD_ONE;
                        if (r_count == c_LAST_COUNT) begin
                            r_fill_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_state         <= S_REQ;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fill_busy        = (r_state != S_IDLE);
    assign bus.fill_done        = r_fill_done;
    assign bus.mem_req_valid    = r_mem_req_valid;
    assign bus.mem_req_addr     = {r_tag, r_set, r_word_idx, 2'b00};
    assign bus.dl_perform_write = r_perform_write;
    assign bus.dl_set           = r_dl_set;
    assign bus.dl_selected_way  = r_dl_way;
    assign bus.dl_word_select   = r_dl_word;
    assign bus.dl_word_to_store = r_dl_data;

endmodule

`default_nettype wire

// File: tb/tb_line_fill_unit.sv
// ============================================================================
// Module      : tb_line_fill_unit
// Description : Self-checking bench for line_fill_unit. Drives directed and
//               randomized fills through a cycle-level memory responder and
//               compares request addresses, array writes, completion timing
//               and abort behaviour against a model of the fill rules.
//               Honours CRITICAL_WORD_FIRST_EN when the design is built
//               with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_fill_unit;
    localparam int XLEN  = 32;
    localparam int SETS  = 4;
    localparam int SS    = 2;
    localparam int WPL   = 8;
    localparam int ASSOC = 1;
    localparam int WS    = $clog2(WPL);
    localparam int TS    = XLEN - SS - WS - 2;
    localparam int WW    = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    line_fill_unit_if #(.XLEN(XLEN), .SET_SIZE(SS), .WORDS_PER_LINE(WPL), .ASSOC(ASSOC)) bus ();

    line_fill_unit #(
        .XLEN(XLEN), .NUM_SETS(SETS), .SET_SIZE(SS), .WORDS_PER_LINE(WPL), .ASSOC(ASSOC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cnt = 0;

    // Observed array writes and completion pulses
    logic [SS-1:0]   wset_q[$];
    logic [WW-1:0]   wway_q[$];
    logic [WS-1:0]   wword_q[$];
    logic [XLEN-1:0] wdata_q[$];
    int              done_q[$];

    // Per-word data the memory model returns for the current fill
    logic [XLEN-1:0] rsp_data[WPL];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_req_valid && bus.mem_req_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (bus.dl_perform_write) begin
            wset_q.push_back(bus.dl_set);
            wway_q.push_back(bus.dl_selected_way);
            wword_q.push_back(bus.dl_word_select);
            wdata_q.push_back(bus.dl_word_to_store);
        end
        if (bus.fill_done) done_q.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one fill and checks it against the model: words are fetched in
    // order start, start+1, ... modulo WPL; each response is written once;
    // fill_done arrives 3*WPL+1 cycles after fill_req plus any stall cycles.
    task automatic run_fill(input logic [TS-1:0] tag, input logic [SS-1:0] set,
                            input logic [WW-1:0] way, input logic [WS-1:0] fword,
                            input int stall_k, input int stall_n, input bit noise,
                            input int abort_after);
        int wbase, dbase, abase, t0, start, idx, n, nw;
        logic [XLEN-1:0] exp_addr;
        wbase = wset_q.size();
        dbase = done_q.size();
        abase = acc_cnt;
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(fword);
`else
        start = 0;
`endif
        bus.fill_tag  = tag;
        bus.fill_set  = set;
        bus.fill_way  = way;
        bus.fill_word = fword;
        bus.fill_req  = 1'b1;
        t0 = cyc;
        tick();
        bus.fill_req = 1'b0;
        chk("busy_after_accept", 64'(bus.fill_busy), 64'd1);
        for (int k = 0; k < WPL; k++) begin
            idx = (start + k) % WPL;
            n = 0;
            while (!bus.mem_req_valid && n < 20) begin
                tick();
                n++;
            end
            chk("req_valid", 64'(bus.mem_req_valid), 64'd1);
            exp_addr = {tag, set, WS'(idx), 2'b00};
            chk("req_addr", 64'(bus.mem_req_addr), 64'(exp_addr));
            if (k == stall_k) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus.mem_req_ready = 1'b0;
                    if (noise) begin
                        bus.fill_req      = 1'b1;
                        bus.fill_tag      = TS'($urandom);
                        bus.fill_set      = SS'($urandom);
                        bus.fill_word     = WS'($urandom);
                        bus.mem_rsp_valid = 1'b1;
                        bus.mem_rsp_data  = $urandom;
                    end
                    tick();
                    bus.fill_req      = 1'b0;
                    bus.mem_rsp_valid = 1'b0;
                    chk("stall_valid", 64'(bus.mem_req_valid), 64'd1);
                    chk("stall_addr", 64'(bus.mem_req_addr), 64'(exp_addr));
                end
            end
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            chk("req_drop", 64'(bus.mem_req_valid), 64'd0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = rsp_data[idx];
            tick();
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = $urandom;
            if (k + 1 == abort_after) begin
                tick();
                reset = 1'b1;
                tick();
                tick();
                reset = 1'b0;
                bus.mem_rsp_valid = 1'b1;
                tick();
                bus.mem_rsp_valid = 1'b0;
                repeat (4) tick();
                chk("abort_busy", 64'(bus.fill_busy), 64'd0);
                chk("abort_req_valid", 64'(bus.mem_req_valid), 64'd0);
                chk("abort_write_count", 64'(wset_q.size() - wbase), 64'(abort_after));
                chk("abort_done_count", 64'(done_q.size() - dbase), 64'd0);
                return;
            end
        end
        repeat (3) tick();
        nw = wset_q.size() - wbase;
        chk("write_count", 64'(nw), 64'(WPL));
        for (int k = 0; k < WPL && k < nw; k++) begin
            idx = (start + k) % WPL;
            chk("write_word", 64'(wword_q[wbase + k]), 64'(idx));
            chk("write_set",  64'(wset_q[wbase + k]),  64'(set));
            chk("write_way",  64'(wway_q[wbase + k]),  64'(way));
            chk("write_data", 64'(wdata_q[wbase + k]), 64'(rsp_data[idx]));
        end
        chk("done_count", 64'(done_q.size() - dbase), 64'd1);
        if (done_q.size() > dbase)
            chk("done_latency", 64'(done_q[dbase] - t0),
                64'(3 * WPL + 1 + ((stall_k >= 0) ? stall_n : 0)));
        chk("accepted_reqs", 64'(acc_cnt - abase), 64'(WPL));
        chk("idle_busy", 64'(bus.fill_busy), 64'd0);
    endtask

    task automatic randomize_data();
        for (int i = 0; i < WPL; i++) rsp_data[i] = $urandom;
    endtask

    initial begin
        int wb;
        bus.fill_req      = 1'b0;
        bus.fill_tag      = '0;
        bus.fill_set      = '0;
        bus.fill_way      = '0;
        bus.fill_word     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy",      64'(bus.fill_busy),        64'd0);
        chk("rst_done",      64'(bus.fill_done),        64'd0);
        chk("rst_req_valid", 64'(bus.mem_req_valid),    64'd0);
        chk("rst_req_addr",  64'(bus.mem_req_addr),     64'd0);
        chk("rst_write",     64'(bus.dl_perform_write), 64'd0);
        chk("rst_dl_data",   64'(bus.dl_word_to_store), 64'd0);
        chk("rst_dl_word",   64'(bus.dl_word_select),   64'd0);
        reset = 1'b0;
        tick();

        // Basic fill with data 0xA0+idx
        for (int i = 0; i < WPL; i++) rsp_data[i] = 32'hA0 + 32'(i);
        run_fill(TS'(32'h1234), 2'd2, 1'b0, 3'd0, -1, 0, 1'b0, 0);

        // Backpressure: ready low for 3 cycles on word 3
        randomize_data();
        run_fill(TS'($urandom), 2'd1, 1'b0, 3'd0, 3, 3, 1'b0, 0);

        // Ignored fill_req and spurious responses while in REQ
        randomize_data();
        run_fill(TS'($urandom), 2'd3, 1'b0, 3'd0, 2, 2, 1'b1, 0);

        // Abort after the third write, then a fresh fill from word 0
        randomize_data();
        run_fill(TS'($urandom), 2'd0, 1'b0, 3'd0, -1, 0, 1'b0, 3);
        randomize_data();
        run_fill(TS'($urandom), 2'd2, 1'b0, 3'd0, -1, 0, 1'b0, 0);

        // Response while idle writes nothing
        wb = wset_q.size();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = $urandom;
        tick();
        bus.mem_rsp_valid = 1'b0;
        repeat (3) tick();
        chk("idle_rsp_writes", 64'(wset_q.size() - wb), 64'd0);

        // Fill with fill_word=5 (critical-word order when enabled)
        randomize_data();
        run_fill(TS'($urandom), 2'd1, 1'b0, 3'd5, -1, 0, 1'b0, 0);

        // Randomized fills with random stalls and noise
        for (int r = 0; r < 6; r++) begin
            randomize_data();
            run_fill(TS'($urandom), SS'($urandom), WW'($urandom), WS'($urandom),
                     int'($urandom_range(0, WPL - 1)), int'($urandom_range(0, 3)),
                     1'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/line_fill_unit.md
Name: line_fill_unit

Overview:
Cache-miss line fill engine that sits directly upstream of the data-line array. On a fill request it fetches every word of the target line from the next memory level, one outstanding read at a time. It then writes each returned word into the array through the array's write port as a full-word store. It also reports completion so the cache controller can update tag and valid state.

Parameters:
XLEN, 32, data and address width
NUM_SETS, 4, number of sets in the array
SET_SIZE, 2, set index width (= $clog2(NUM_SETS))
WORDS_PER_LINE, 8, words per cache line (power of 2, >= 2)
ASSOC, 1, ways per set; selected-way width is $clog2(ASSOC), min 1 bit
Derived localparams:
- WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE)
- TAG_SIZE = XLEN - SET_SIZE - WORD_SELECT_SIZE - 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fill_req  in  1  start fill; sampled only in IDLE
fill_tag  in  TAG_SIZE  tag of missed line
fill_set  in  SET_SIZE  set of missed line
fill_way  in  $clog2(ASSOC)  victim way to overwrite
fill_word  in  WORD_SELECT_SIZE  word that caused the miss (used only with the optional feature)
fill_busy  out  1  high from acceptance through the DONE cycle
fill_done  out  1  one-cycle pulse after the last word is written
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  {tag, set, word_idx, 2'b00}
mem_rsp_valid  in  1  read data valid
mem_rsp_data  in  XLEN  read data
dl_perform_write  out  1  array write strobe
dl_set  out  SET_SIZE  array set
dl_selected_way  out  $clog2(ASSOC)  array way
dl_word_select  out  WORD_SELECT_SIZE  array word index
dl_word_to_store  out  XLEN  array write data (op_size is tied to WORD at top level)

Behaviour:
Reset: synchronous and active-high. It forces state IDLE and clears the word counter and latched request. All outputs reset to 0.

FSM states: IDLE, REQ, WAIT, DONE.

IDLE:
- fill_req=1 latches tag, set, way and start word (start word is 0 unless the optional feature is enabled).
- Clears the count and moves to REQ next cycle.

REQ:
- mem_req_valid=1 with mem_req_addr built from the latched tag, set and current word_idx.
- mem_req_valid and mem_req_addr stay stable until mem_req_ready=1 on a clock edge; then move to WAIT.

WAIT:
- mem_req_valid=0.
- On mem_rsp_valid=1, register mem_rsp_data and word_idx.
- Next cycle: dl_perform_write=1 for exactly one cycle with dl_set/dl_selected_way/dl_word_select/dl_word_to_store driven from those registers.
- In the same edge, the count increments and word_idx increments modulo WORDS_PER_LINE.
- If this was response number WORDS_PER_LINE, go to DONE; otherwise go to REQ.
- The write of word N overlaps the REQ of word N+1.

DONE:
- fill_done=1 for one cycle; fill_busy stays high.
- Next state is IDLE.
- The final array write and fill_done land in the same cycle.

Rules:
- fill_busy = (state != IDLE).
- Only one request is outstanding at any time.
- mem_rsp_valid outside WAIT is ignored and writes nothing.
- fill_req while busy is ignored; there is no queueing.
- The dl_* outputs other than dl_perform_write hold their last values when idle; the array ignores them.
- Reset mid-fill aborts immediately with no further writes. A stale response arriving after reset lands in IDLE and is ignored.
- Fill latency with mem_req_ready=1 and response one cycle after acceptance: 3*WORDS_PER_LINE+1 cycles from fill_req to fill_done.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: the start word is latched from fill_word, and requests proceed fill_word, fill_word+1, ... wrapping modulo WORDS_PER_LINE. The word count still terminates after exactly WORDS_PER_LINE responses.
- Undefined: fill_word is unused and order is always 0..WORDS_PER_LINE-1.

Test Plan:
1. Basic fill: reset, fill_req with tag=0x1234, set=2, way=0, mem_req_ready=1, response 1 cycle after each request with data=0xA0+idx.
   - Required: 8 writes to set 2, words 0..7, data 0xA0..0xA7.
   - Required: request addresses {0x1234,2'd2,idx,2'b00}.
   - Required: single fill_done pulse 25 cycles after fill_req.
2. Backpressure: mem_req_ready low for 3 cycles on word 3.
   - Required: mem_req_addr for word 3 held stable for all 4 cycles and exactly one request accepted.
   - Required: no duplicate write.
3. Ignored inputs: fill_req pulsed while busy, and a spurious mem_rsp_valid during REQ.
   - Required: exactly 8 writes and a single fill_done.
4. Abort: reset asserted after the third write, then a late mem_rsp_valid.
   - Required: zero further dl_perform_write, fill_busy=0, next fill starts at word 0.
5. With CRITICAL_WORD_FIRST_EN, fill_word=5.
   - Required: write order 5,6,7,0,1,2,3,4.
   - Required: fill_done after 8th write; an idle response between fills causes no write.
